// File: rtl/apple_placement_gen.sv
// Apple placement generator: draws LFSR candidates, rejects out-of-bounds/wall/body
// cells locally, and in wall mode consults the external dead-end checker.
module apple_placement_gen #(
    parameter int          MAX_LENGTH    = 50,
    parameter int          CHECK_LATENCY = 2,
    parameter int          MAX_TRIES     = 32,
    parameter logic [7:0]  SEED          = 8'hA5,
    parameter logic [7:0]  DEFAULT_APPLE = 8'h44
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    apple_request,
    input  logic                    wall_mode_en,
    input  logic [3:0]              xmax,
    input  logic [3:0]              xmin,
    input  logic [3:0]              ymax,
    input  logic [3:0]              ymin,
    input  logic [199:0]            wall_locations,
    input  logic [8*MAX_LENGTH-1:0] snake_body,
    input  logic [7:0]              snake_length,
    input  logic                    impossible,
    output logic [7:0]              apple_possible,
    output logic [7:0]              apple_location,
    output logic                    apple_valid,
    output logic                    busy,
    output logic                    fail
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int CW = (CHECK_LATENCY > 1) ? $clog2(CHECK_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, PROPOSE, WAIT, DONE, FAIL} state_t;

    state_t        state;
    logic [7:0]    lfsr;
    logic [TW-1:0] tries;
    logic [TW-1:0] tries_inc;
    logic [CW-1:0] wait_cnt;
    logic          reject;
    logic          feedback;

    assign feedback  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign tries_inc = tries + 1'b1;

    always_comb begin
        reject = 1'b0;
        if (lfsr[3:0] <= xmin || lfsr[3:0] >= xmax ||
            lfsr[7:4] <= ymin || lfsr[7:4] >= ymax)
            reject = 1'b1;
        for (int unsigned i = 0; i < 25; i++) begin
            if (wall_locations[8*i +: 8] != 8'h00 && wall_locations[8*i +: 8] == lfsr)
                reject = 1'b1;
        end
        // Iterating only to MAX_LENGTH clamps an oversized snake_length implicitly.
        for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
            if (i < 32'(snake_length) && snake_body[8*i +: 8] == lfsr)
                reject = 1'b1;
        end
    end

    // Flags are registered on entry to DONE/FAIL so each pulse spans exactly that state cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            lfsr           <= SEED;
            apple_possible <= '0;
            apple_location <= DEFAULT_APPLE;
            apple_valid    <= 1'b0;
            busy           <= 1'b0;
            fail           <= 1'b0;
            tries          <= '0;
            wait_cnt       <= '0;
        end else begin
            lfsr        <= (lfsr == 8'h00) ? SEED : {lfsr[6:0], feedback};
            apple_valid <= 1'b0;
            fail        <= 1'b0;
            case (state)
                IDLE: begin
                    if (apple_request) begin
                        state <= PROPOSE;
                        tries <= '0;
                        busy  <= 1'b1;
                    end
                end
                PROPOSE: begin
                    apple_possible <= lfsr;
                    tries          <= tries_inc;
                    if (reject) begin
                        if (tries_inc == TW'(MAX_TRIES)) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end
                    end else if (wall_mode_en) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end else begin
                        state          <= DONE;
                        apple_valid    <= 1'b1;
                        apple_location <= lfsr;
                    end
                end
                WAIT: begin
                    if (wait_cnt == CW'(CHECK_LATENCY - 1)) begin
                        if (!impossible) begin
                            state          <= DONE;
                            apple_valid    <= 1'b1;
                            apple_location <= apple_possible;
                        end else if (tries == TW'(MAX_TRIES)) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state <= PROPOSE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                FAIL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apple_placement_gen.sv
// Directed, table-driven bench for apple_placement_gen with a cycle-level reference model.
module tb_apple_placement_gen;

    localparam int         MAX_LEN = 50;
    localparam int         LAT     = 2;
    localparam int         TRIES   = 32;
    localparam logic [7:0] SEED_V  = 8'hA5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 apple_request;
    logic                 wall_mode_en;
    logic [3:0]           xmax, xmin, ymax, ymin;
    logic [199:0]         wall_locations;
    logic [8*MAX_LEN-1:0] snake_body;
    logic [7:0]           snake_length;
    logic                 impossible;
    logic [7:0]           apple_possible;
    logic [7:0]           apple_location;
    logic                 apple_valid;
    logic                 busy;
    logic                 fail;

    apple_placement_gen #(
        .MAX_LENGTH(MAX_LEN), .CHECK_LATENCY(LAT), .MAX_TRIES(TRIES),
        .SEED(SEED_V), .DEFAULT_APPLE(8'h44)
    ) dut (
        .clk(clk), .reset(reset), .apple_request(apple_request),
        .wall_mode_en(wall_mode_en), .xmax(xmax), .xmin(xmin), .ymax(ymax), .ymin(ymin),
        .wall_locations(wall_locations), .snake_body(snake_body),
        .snake_length(snake_length), .impossible(impossible),
        .apple_possible(apple_possible), .apple_location(apple_location),
        .apple_valid(apple_valid), .busy(busy), .fail(fail)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] m;        // reference LFSR, mirrors x^8+x^6+x^5+x^4+1
    logic [7:0] exp_loc;

    function automatic logic [7:0] step(input logic [7:0] v);
        return (v == 8'h00) ? SEED_V : {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk) m <= reset ? SEED_V : step(m);

    function automatic bit cand_ok(input logic [7:0] c);
        if (c[3:0] <= xmin || c[3:0] >= xmax || c[7:4] <= ymin || c[7:4] >= ymax) return 1'b0;
        for (int i = 0; i < 25; i++)
            if (wall_locations[8*i +: 8] != 8'h00 && wall_locations[8*i +: 8] == c) return 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(snake_length) && snake_body[8*i +: 8] == c) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_env(input logic [3:0] x0, input logic [3:0] x1,
                           input logic [3:0] y0, input logic [3:0] y1, input int bm);
        logic [7:0] cells [4];
        cells[0] = 8'h33; cells[1] = 8'h34; cells[2] = 8'h43; cells[3] = 8'h44;
        xmin = x0; xmax = x1; ymin = y0; ymax = y1;
        wall_locations = '0; snake_body = '0; snake_length = 8'd0;
        for (int i = 0; i < 4; i++) begin
            case (bm)
                1: snake_body[8*i +: 8] = cells[i];
                2: wall_locations[8*i +: 8] = cells[i];
                3, 4: snake_body[8*(46+i) +: 8] = cells[i];
                default: ;
            endcase
        end
        case (bm)
            1: snake_length = 8'd4;
            3: snake_length = 8'd255;
            4: snake_length = 8'd46;
            default: ;
        endcase
    endtask

    // One request, checked cycle by cycle against the reference model.
    task automatic run_req(input bit wm, input bit imp, input bit align,
                           output bit got_fail, output int props, output int cyc,
                           output logic [7:0] cand);
        bit ok;
        bit done;
        int n;
        wall_mode_en = wm;
        impossible   = imp;
        @(negedge clk);
        n = 0;
        while (align && !cand_ok(step(m)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        apple_request = 1'b1;
        @(posedge clk); #1;
        apple_request = 1'b0;
        check("busy_on_accept", busy, 1);
        cyc = 1; props = 0; done = 1'b0; got_fail = 1'b0; cand = 8'h00;
        while (!done) begin
            cand = m;
            props++;
            ok = cand_ok(cand);
            @(posedge clk); #1; cyc++;
            check("possible_latch", apple_possible, cand);
            if (!ok) begin
                if (props == TRIES) begin got_fail = 1'b1; done = 1'b1; end
            end else if (!wm) begin
                done = 1'b1;
            end else begin
                for (int k = 0; k < LAT; k++) begin
                    check("possible_hold", apple_possible, cand);
                    check("no_pulse_in_wait", {apple_valid, fail}, 0);
                    @(posedge clk); #1; cyc++;
                end
                if (!imp) done = 1'b1;
                else if (props == TRIES) begin got_fail = 1'b1; done = 1'b1; end
            end
        end
        if (got_fail) begin
            check("fail_pulse", {fail, apple_valid}, 2'b10);
            check("loc_kept", apple_location, exp_loc);
        end else begin
            check("valid_pulse", {apple_valid, fail}, 2'b10);
            check("loc_commit", apple_location, cand);
            exp_loc = cand;
        end
        check("busy_last", busy, 1);
        @(posedge clk); #1;
        check("idle_flags", {busy, apple_valid, fail}, 0);
    endtask

    typedef struct {
        logic [3:0] x0, x1, y0, y1;
        bit wm, imp, align;
        int bm, exp_fail, exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit gf;
        int props, cyc, nvalid;
        logic [7:0] cand;

        vecs[0] = '{4'd0, 4'd15, 4'd0, 4'd15, 1'b0, 1'b0, 1'b1, 0, 0, 2};
        vecs[1] = '{4'd0, 4'd15, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 0, 0, 4};
        vecs[2] = '{4'd0, 4'd15, 4'd0, 4'd15, 1'b1, 1'b1, 1'b0, 0, 1, 0};
        vecs[3] = '{4'd2, 4'd5,  4'd2, 4'd5,  1'b0, 1'b0, 1'b0, 1, 1, 33};
        vecs[4] = '{4'd2, 4'd5,  4'd2, 4'd5,  1'b1, 1'b0, 1'b0, 2, 1, 33};
        vecs[5] = '{4'd2, 4'd5,  4'd2, 4'd5,  1'b0, 1'b0, 1'b0, 3, 1, 33};
        vecs[6] = '{4'd2, 4'd5,  4'd2, 4'd5,  1'b0, 1'b0, 1'b1, 4, 0, 2};
        vecs[7] = '{4'd1, 4'd3,  4'd1, 4'd3,  1'b0, 1'b0, 1'b1, 0, 0, 2};

        reset = 1'b1; apple_request = 1'b0; wall_mode_en = 1'b0; impossible = 1'b0;
        set_env(4'd0, 4'd15, 4'd0, 4'd15, 0);
        exp_loc = 8'h44;
        repeat (3) @(posedge clk);
        #1;
        check("rst_location", apple_location, 8'h44);
        check("rst_possible", apple_possible, 8'h00);
        check("rst_flags", {apple_valid, busy, fail}, 0);
        @(negedge clk) reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            set_env(vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1, vecs[v].bm);
            run_req(vecs[v].wm, vecs[v].imp, vecs[v].align, gf, props, cyc, cand);
            if (vecs[v].exp_fail != 2) check($sformatf("vec%0d_fail", v), gf, vecs[v].exp_fail);
            if (vecs[v].exp_fail == 1) check($sformatf("vec%0d_props", v), props, TRIES);
            if (vecs[v].exp_lat != 0) check($sformatf("vec%0d_lat", v), cyc, vecs[v].exp_lat);
        end

        set_env(4'd2, 4'd5, 4'd2, 4'd5, 0);
        for (int r = 0; r < 200; r++) begin
            run_req(1'b0, 1'b0, 1'b0, gf, props, cyc, cand);
            if (!gf)
                check("range", (cand[3:0] inside {4'd3, 4'd4}) && (cand[7:4] inside {4'd3, 4'd4}), 1);
        end

        // Request held high throughout an attempt: only one commit.
        set_env(4'd0, 4'd15, 4'd0, 4'd15, 0);
        wall_mode_en = 1'b1; impossible = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 400 && !cand_ok(step(m)); n++) @(negedge clk);
        cand = step(m);
        apple_request = 1'b1;
        nvalid = 0;
        for (int n = 0; n < 50 && nvalid == 0; n++) begin
            @(posedge clk); #1;
            if (apple_valid) nvalid++;
        end
        apple_request = 1'b0;
        check("held_req_loc", apple_location, cand);
        exp_loc = cand;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (apple_valid) nvalid++;
        end
        check("held_req_commits", nvalid, 1);
        check("held_req_idle", busy, 0);

        // Reset during WAIT abandons the attempt silently.
        @(negedge clk);
        for (int n = 0; n < 400 && !cand_ok(step(m)); n++) @(negedge clk);
        apple_request = 1'b1;
        @(posedge clk); #1;
        apple_request = 1'b0;
        @(posedge clk); #1;
        check("in_wait", {busy, apple_possible}, {1'b1, cand_ok(apple_possible) ? apple_possible : 8'hxx});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_loc = 8'h44;
        check("rst_wait_loc", apple_location, 8'h44);
        check("rst_wait_flags", {busy, apple_valid, fail, apple_possible}, 0);
        nvalid = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (apple_valid || fail || busy) nvalid++;
        end
        check("rst_wait_quiet", nvalid, 0);

        // LFSR continues correctly after reset: next commit matches reference.
        wall_mode_en = 1'b0;
        run_req(1'b0, 1'b0, 1'b1, gf, props, cyc, cand);
        check("post_rst_lat", cyc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
